// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared definitions for the multi-cycle MIPS-subset controller.
// Holds the FSM state encodings, the latched instruction class, the opcode and
// funct code points, the ALUcontrol code points, the PC-source selects and a few
// helper functions that map an instruction class to its ALU controls.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB_ALU = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    C_NONE = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_AND  = 4'd3,
    C_OR   = 4'd4,
    C_SLT  = 4'd5,
    C_LW   = 4'd6,
    C_SW   = 4'd7,
    C_ADDI = 4'd8,
    C_ANDI = 4'd9,
    C_ORI  = 4'd10,
    C_LUI  = 4'd11,
    C_JAL  = 4'd12,
    C_BEQ  = 4'd13
  } instr_class_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALUcontrol code points
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUBU = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_LW   = 4'b0110;
  localparam logic [3:0] ALU_SW   = 4'b0111;
  localparam logic [3:0] ALU_ADDI = 4'b1000;
  localparam logic [3:0] ALU_ANDI = 4'b1001;
  localparam logic [3:0] ALU_ORI  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  // PC source selects
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic [3:0] alu_code(input instr_class_t c);
    case (c)
      C_ADDU:  return ALU_ADDU;
      C_SUBU:  return ALU_SUBU;
      C_AND:   return ALU_AND;
      C_OR:    return ALU_OR;
      C_SLT:   return ALU_SLT;
      C_LW:    return ALU_LW;
      C_SW:    return ALU_SW;
      C_ADDI:  return ALU_ADDI;
      C_ANDI:  return ALU_ANDI;
      C_ORI:   return ALU_ORI;
      C_LUI:   return ALU_LUI;
      default: return ALU_NONE;
    endcase
  endfunction

  function automatic logic is_rtype(input instr_class_t c);
    return (c == C_ADDU) || (c == C_SUBU) || (c == C_AND) ||
           (c == C_OR)   || (c == C_SLT);
  endfunction

  function automatic logic is_alu_imm(input instr_class_t c);
    return (c == C_ADDI) || (c == C_ANDI) || (c == C_ORI) || (c == C_LUI);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath bundle.
// Carries the IR fields and ALU zero flag into the controller and the datapath
// enables/selects out of it. With MEM_WAIT_EN defined the bundle also carries
// the memory handshake mem_ready.
//   master : controller side (inputs op/func/zero[/mem_ready], drives controls)
//   slave  : datapath side
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic [3:0] ALUcontrol;
  logic       WritePC;
  logic       WriteIR;
  logic       ReadMem;
  logic       WriteReg;
  logic       MemToReg;
  logic       WriteMem;
  logic       RegDes;
  logic       ALUSrcB;
  logic       PcToReg;
  logic [1:0] PCSrc;

`ifdef MEM_WAIT_EN
  modport master (
    input  op, func, zero, mem_ready,
    output ALUcontrol, WritePC, WriteIR, ReadMem, WriteReg, MemToReg,
           WriteMem, RegDes, ALUSrcB, PcToReg, PCSrc
  );
  modport slave (
    output op, func, zero, mem_ready,
    input  ALUcontrol, WritePC, WriteIR, ReadMem, WriteReg, MemToReg,
           WriteMem, RegDes, ALUSrcB, PcToReg, PCSrc
  );
`else
  modport master (
    input  op, func, zero,
    output ALUcontrol, WritePC, WriteIR, ReadMem, WriteReg, MemToReg,
           WriteMem, RegDes, ALUSrcB, PcToReg, PCSrc
  );
  modport slave (
    output op, func, zero,
    input  ALUcontrol, WritePC, WriteIR, ReadMem, WriteReg, MemToReg,
           WriteMem, RegDes, ALUSrcB, PcToReg, PCSrc
  );
`endif
endinterface

// File: rtl/mc_controller_decode.sv
// mc_decode: combinational instruction decoder.
// Ports:
//   op      in  6  IR[31:26]
//   func    in  6  IR[5:0]
//   cls     out    instruction class (C_NONE when not decodable)
//   illegal out 1  instruction is outside the supported subset
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls = C_NONE;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: cls = C_ADDU;
          FN_SUBU: cls = C_SUBU;
          FN_AND:  cls = C_AND;
          FN_OR:   cls = C_OR;
          FN_SLT:  cls = C_SLT;
          default: cls = C_NONE;
        endcase
      end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_ADDI: cls = C_ADDI;
      OP_ANDI: cls = C_ANDI;
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_JAL:  cls = C_JAL;
      OP_BEQ:  cls = C_BEQ;
      default: cls = C_NONE;
    endcase
    illegal = (cls == C_NONE);
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for the MIPS-subset core.
// Sequences fetch/decode/execute/memory/writeback, drives the datapath
// enables, selects the PC source and counts retired instructions.
// Optional feature macro: MEM_WAIT_EN (adds mem_ready handshake; FETCH,
// MEM_RD and MEM_WR hold until mem_ready=1).
// Ports:
//   clk          in        core clock, rising edge
//   rst_n        in        asynchronous active-low reset
//   bus          master    op/func/zero[/mem_ready] in, datapath controls out
//   illegal      out 1     one-cycle pulse in DECODE on undecodable instruction
//   state        out 4     current state (debug)
//   instr_count  out CNT_W retired-instruction counter, wraps
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_controller_if.master  bus,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t       state_q;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic         dec_illegal;
  logic         mem_ok;

  logic [3:0] alu_ctl;
  logic       write_pc;
  logic       write_ir;
  logic       read_mem;
  logic       write_reg;
  logic       mem_to_reg;
  logic       write_mem;
  logic       reg_des;
  logic       alu_src_b;
  logic       pc_to_reg;
  logic [1:0] pc_src;

`ifdef MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  mc_decode u_decode (
    .op      (bus.op),
    .func    (bus.func),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // State, class and retire counter. Memory states advance only when the
  // memory side is ready (always ready without MEM_WAIT_EN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cls_q       <= C_NONE;
      instr_count <= '0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (mem_ok) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q <= dec_cls;
          case (dec_cls)
            C_ADDU, C_SUBU, C_AND, C_OR, C_SLT,
            C_ADDI, C_ANDI, C_ORI, C_LUI: state_q <= S_EXEC;
            C_LW, C_SW:                   state_q <= S_ADDR;
            C_BEQ:                        state_q <= S_BRANCH;
            C_JAL:                        state_q <= S_JAL;
            default:                      state_q <= S_FETCH;
          endcase
        end
        S_EXEC:   state_q <= S_WB_ALU;
        S_WB_ALU: begin
          state_q     <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        S_ADDR:   state_q <= (cls_q == C_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (mem_ok) state_q <= S_WB_MEM;
        S_MEM_WR: begin
          if (mem_ok) begin
            state_q     <= S_FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        S_WB_MEM, S_BRANCH, S_JAL: begin
          state_q     <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode purely from state and latched class (plus zero in BRANCH
  // and mem_ready in FETCH), so a reset returns every control to 0 at once.
  always_comb begin
    alu_ctl    = ALU_NONE;
    write_pc   = 1'b0;
    write_ir   = 1'b0;
    read_mem   = 1'b0;
    write_reg  = 1'b0;
    mem_to_reg = 1'b0;
    write_mem  = 1'b0;
    reg_des    = 1'b0;
    alu_src_b  = 1'b0;
    pc_to_reg  = 1'b0;
    pc_src     = PC_SEQ;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        read_mem = 1'b1;
        write_ir = mem_ok;
        write_pc = mem_ok;
        pc_src   = PC_SEQ;
      end
      S_DECODE: illegal = dec_illegal;
      S_EXEC: begin
        alu_ctl   = alu_code(cls_q);
        alu_src_b = !is_alu_imm(cls_q);
      end
      S_WB_ALU: begin
        alu_ctl   = alu_code(cls_q);
        alu_src_b = !is_alu_imm(cls_q);
        write_reg = 1'b1;
        reg_des   = is_rtype(cls_q);
      end
      S_ADDR: begin
        alu_ctl   = (cls_q == C_LW) ? ALU_LW : ALU_SW;
        alu_src_b = 1'b0;
      end
      S_MEM_RD: read_mem = 1'b1;
      S_MEM_WR: write_mem = 1'b1;
      S_WB_MEM: begin
        write_reg  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_ctl   = ALU_SUBU;
        alu_src_b = 1'b1;
        write_pc  = bus.zero;
        pc_src    = PC_BRANCH;
      end
      S_JAL: begin
        write_reg = 1'b1;
        pc_to_reg = 1'b1;
        write_pc  = 1'b1;
        pc_src    = PC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.ALUcontrol = alu_ctl;
  assign bus.WritePC    = write_pc;
  assign bus.WriteIR    = write_ir;
  assign bus.ReadMem    = read_mem;
  assign bus.WriteReg   = write_reg;
  assign bus.MemToReg   = mem_to_reg;
  assign bus.WriteMem   = write_mem;
  assign bus.RegDes     = reg_des;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.PcToReg    = pc_to_reg;
  assign bus.PCSrc      = pc_src;
  assign state          = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller.
// The driver sets op/func/zero and pushes the hand-written expected outputs
// for each cycle; an independent monitor pops one record per falling edge
// and compares state, control flags, ALUcontrol, PCSrc, illegal and count.
// Flag vector order: {WritePC,WriteIR,ReadMem,WriteReg,MemToReg,WriteMem,
// RegDes,ALUSrcB,PcToReg}. A 3-bit counter is used so wrap is exercised.
module tb_mc_controller;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          illegal;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  mc_controller_if bif ();

  mc_controller #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bif),
    .illegal     (illegal),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [8:0]    fl;
    logic [3:0]    alu;
    logic [1:0]    pcs;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  localparam logic [8:0] F_NONE   = 9'b000_000_000;
  localparam logic [8:0] F_FETCH  = 9'b111_000_000;
  localparam logic [8:0] F_FWAIT  = 9'b001_000_000;
  localparam logic [8:0] F_EXEC_R = 9'b000_000_010;
  localparam logic [8:0] F_WB_R   = 9'b000_100_110;
  localparam logic [8:0] F_WB_I   = 9'b000_100_000;
  localparam logic [8:0] F_MEMRD  = 9'b001_000_000;
  localparam logic [8:0] F_WBMEM  = 9'b000_110_000;
  localparam logic [8:0] F_MEMWR  = 9'b000_001_000;
  localparam logic [8:0] F_BR_T   = 9'b100_000_010;
  localparam logic [8:0] F_BR_N   = 9'b000_000_010;
  localparam logic [8:0] F_JAL    = 9'b100_100_001;

  exp_t          q[$];
  string         tags[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt;

  exp_t  mon_e;
  exp_t  mon_a;
  string mon_tag;

  // Monitor: one expected record per falling edge while any are queued.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_tag = tags.pop_front();
      mon_a.st  = state;
      mon_a.fl  = {bif.WritePC, bif.WriteIR, bif.ReadMem, bif.WriteReg,
                   bif.MemToReg, bif.WriteMem, bif.RegDes, bif.ALUSrcB,
                   bif.PcToReg};
      mon_a.alu = bif.ALUcontrol;
      mon_a.pcs = bif.PCSrc;
      mon_a.ill = illegal;
      mon_a.cnt = instr_count;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got st=%0d fl=%b alu=%b pcs=%b ill=%b cnt=%0d, expected st=%0d fl=%b alu=%b pcs=%b ill=%b cnt=%0d",
                 mon_tag, mon_a.st, mon_a.fl, mon_a.alu, mon_a.pcs, mon_a.ill, mon_a.cnt,
                 mon_e.st, mon_e.fl, mon_e.alu, mon_e.pcs, mon_e.ill, mon_e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue the expectation for the coming falling edge, then move to 2 time
  // units after the next rising edge (the point where the next state shows).
  task automatic push_exp(input string tag, input logic [3:0] st, input logic [8:0] fl,
                          input logic [3:0] alu, input logic [1:0] pcs, input logic ill);
    exp_t e;
    e.st = st; e.fl = fl; e.alu = alu; e.pcs = pcs; e.ill = ill; e.cnt = exp_cnt;
    q.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [8:0] fl,
                      input logic [3:0] alu, input logic [1:0] pcs, input logic ill);
    push_exp(tag, st, fl, alu, pcs, ill);
    @(posedge clk);
    #2;
  endtask

  task automatic retire();
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic do_r(input string n, input logic [5:0] fn, input logic [3:0] alu);
    bif.op = 6'h00; bif.func = fn;
    step({n, "_fetch"},  4'd1, F_FETCH,  4'b0000, 2'b00, 1'b0);
    step({n, "_decode"}, 4'd2, F_NONE,   4'b0000, 2'b00, 1'b0);
    step({n, "_exec"},   4'd3, F_EXEC_R, alu,     2'b00, 1'b0);
    step({n, "_wb"},     4'd4, F_WB_R,   alu,     2'b00, 1'b0);
    retire();
  endtask

  task automatic do_i(input string n, input logic [5:0] opc, input logic [3:0] alu);
    bif.op = opc; bif.func = 6'h3F;
    step({n, "_fetch"},  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step({n, "_decode"}, 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    step({n, "_exec"},   4'd3, F_NONE,  alu,     2'b00, 1'b0);
    step({n, "_wb"},     4'd4, F_WB_I,  alu,     2'b00, 1'b0);
    retire();
  endtask

  task automatic do_lw();
    bif.op = 6'h23; bif.func = 6'h00;
    step("lw_fetch",  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step("lw_decode", 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    step("lw_addr",   4'd5, F_NONE,  4'b0110, 2'b00, 1'b0);
    step("lw_memrd",  4'd6, F_MEMRD, 4'b0000, 2'b00, 1'b0);
    step("lw_wbmem",  4'd8, F_WBMEM, 4'b0000, 2'b00, 1'b0);
    retire();
  endtask

  task automatic do_sw();
    bif.op = 6'h2B; bif.func = 6'h00;
    step("sw_fetch",  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step("sw_decode", 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    step("sw_addr",   4'd5, F_NONE,  4'b0111, 2'b00, 1'b0);
    step("sw_memwr",  4'd7, F_MEMWR, 4'b0000, 2'b00, 1'b0);
    retire();
  endtask

  // zero is held at the opposite value until the BRANCH cycle itself.
  task automatic do_beq(input logic z);
    bif.op = 6'h04; bif.func = 6'h00; bif.zero = ~z;
    step("beq_fetch",  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step("beq_decode", 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    bif.zero = z;
    step(z ? "beq_taken" : "beq_not_taken", 4'd9, z ? F_BR_T : F_BR_N, 4'b0010, 2'b01, 1'b0);
    bif.zero = 1'b0;
    retire();
  endtask

  task automatic do_jal();
    bif.op = 6'h03; bif.func = 6'h00;
    step("jal_fetch",  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step("jal_decode", 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    step("jal_exec",   4'd10, F_JAL,  4'b0000, 2'b10, 1'b0);
    retire();
  endtask

  task automatic do_illegal(input string n, input logic [5:0] opc, input logic [5:0] fn);
    bif.op = opc; bif.func = fn;
    step({n, "_fetch"},  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step({n, "_decode"}, 4'd2, F_NONE,  4'b0000, 2'b00, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    bif.op   = 6'h00;
    bif.func = 6'h00;
    bif.zero = 1'b0;
`ifdef MEM_WAIT_EN
    bif.mem_ready = 1'b1;
`endif
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #2;
    step("reset_state", 4'd0, F_NONE, 4'b0000, 2'b00, 1'b0);
    rst_n = 1'b1;
    step("idle", 4'd0, F_NONE, 4'b0000, 2'b00, 1'b0);

    do_r("addu", 6'h21, 4'b0001);
    do_r("subu", 6'h23, 4'b0010);
    do_r("and",  6'h24, 4'b0011);
    do_r("or",   6'h25, 4'b0100);
    do_r("slt",  6'h2A, 4'b0101);
    do_i("addi", 6'h08, 4'b1000);
    do_i("andi", 6'h0C, 4'b1001);
    do_i("ori",  6'h0D, 4'b1010);
    do_i("lui",  6'h0F, 4'b1111);
    do_lw();
    do_sw();
    do_beq(1'b1);
    do_beq(1'b0);
    do_jal();
    do_illegal("ill_op3f", 6'h3F, 6'h00);
    do_illegal("ill_func", 6'h00, 6'h3F);
    do_r("addu_post_ill", 6'h21, 4'b0001);

    // Reset while addu sits in EXEC: must drop to IDLE with count cleared.
    bif.op = 6'h00; bif.func = 6'h21;
    step("rst_addu_fetch",  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step("rst_addu_decode", 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    push_exp("rst_addu_exec", 4'd3, F_EXEC_R, 4'b0001, 2'b00, 1'b0);
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    exp_cnt = '0;
    @(posedge clk);
    #2;
    step("rst_mid_exec", 4'd0, F_NONE, 4'b0000, 2'b00, 1'b0);
    rst_n = 1'b1;
    step("rst_release_idle", 4'd0, F_NONE, 4'b0000, 2'b00, 1'b0);
    do_r("addu_after_rst", 6'h21, 4'b0001);

`ifdef MEM_WAIT_EN
    bif.op = 6'h23; bif.func = 6'h00;
    bif.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step("lww_fetch_wait", 4'd1, F_FWAIT, 4'b0000, 2'b00, 1'b0);
    bif.mem_ready = 1'b1;
    step("lww_fetch",  4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    step("lww_decode", 4'd2, F_NONE,  4'b0000, 2'b00, 1'b0);
    step("lww_addr",   4'd5, F_NONE,  4'b0110, 2'b00, 1'b0);
    step("lww_memrd",  4'd6, F_MEMRD, 4'b0000, 2'b00, 1'b0);
    step("lww_wbmem",  4'd8, F_WBMEM, 4'b0000, 2'b00, 1'b0);
    retire();
`endif

    step("final_fetch", 4'd1, F_FETCH, 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
